// File: rtl/int_to_float_n_if.sv
// Stream handshake bundle for int_to_float_n: integer operand in, IEEE-754 single out.
interface int_to_float_n_if #(parameter int INT_WIDTH = 32);
   logic [INT_WIDTH-1:0] input_a;
   logic                 input_rnd;
   logic                 input_a_stb;
   logic                 input_a_ack;
   logic [31:0]          output_z;
   logic                 output_z_stb;
   logic                 output_z_ack;

   modport master (output input_a, input_rnd, input_a_stb, output_z_ack,
                   input  input_a_ack, output_z, output_z_stb);
   modport slave  (input  input_a, input_rnd, input_a_stb, output_z_ack,
                   output input_a_ack, output_z, output_z_stb);
endinterface

// File: rtl/int_to_float_n.sv
// Multi-cycle INT_WIDTH-bit integer to IEEE-754 single converter, RNE or truncating,
// fixed 4-cycle latency from input transfer to output strobe.
module int_to_float_n #(
   parameter int INT_WIDTH = 32,
   parameter bit SIGNED    = 1'b1
) (
   input logic              clk,
   input logic              rst,
   int_to_float_n_if.slave  io
);
   typedef enum logic [2:0] {GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z} state_t;

   state_t               state, state_nx;
   logic [INT_WIDTH-1:0] a, a_nx, mag, mag_nx;
   logic                 rnd, rnd_nx, sign, sign_nx, zero, zero_nx;
   logic                 guard, guard_nx, sticky, sticky_nx;
   logic [7:0]           expo, expo_nx;
   logic [22:0]          mant, mant_nx;
   logic                 ack, ack_nx, stb, stb_nx;
   logic [31:0]          z, z_nx;

   logic                 sign_c;
   logic [INT_WIDTH-1:0] mag_c;
   logic [5:0]           lead;
   logic [62:0]          norm;
   logic [23:0]          inc;

   assign io.input_a_ack  = ack;
   assign io.output_z_stb = stb;
   assign io.output_z     = z;

   // Negating the most negative value wraps back to itself, which read unsigned is 2^(W-1).
   assign sign_c = SIGNED & a[INT_WIDTH-1];
   assign mag_c  = sign_c ? ('0 - a) : a;

   always_comb begin
      lead = '0;
      for (int i = 0; i < INT_WIDTH; i++)
         if (mag[i]) lead = 6'(i);
   end

   // Leading one parked at bit 63 of a 64-bit working word; bit 63 itself is implicit.
   assign norm = 63'(64'(mag) << (6'd63 - lead));
   assign inc  = {1'b0, mant} + 24'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= GET_A;
         a      <= '0;
         mag    <= '0;
         rnd    <= 1'b0;
         sign   <= 1'b0;
         zero   <= 1'b0;
         guard  <= 1'b0;
         sticky <= 1'b0;
         expo   <= '0;
         mant   <= '0;
         ack    <= 1'b0;
         stb    <= 1'b0;
         z      <= '0;
      end else begin
         state  <= state_nx;
         a      <= a_nx;
         mag    <= mag_nx;
         rnd    <= rnd_nx;
         sign   <= sign_nx;
         zero   <= zero_nx;
         guard  <= guard_nx;
         sticky <= sticky_nx;
         expo   <= expo_nx;
         mant   <= mant_nx;
         ack    <= ack_nx;
         stb    <= stb_nx;
         z      <= z_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      a_nx      = a;
      mag_nx    = mag;
      rnd_nx    = rnd;
      sign_nx   = sign;
      zero_nx   = zero;
      guard_nx  = guard;
      sticky_nx = sticky;
      expo_nx   = expo;
      mant_nx   = mant;
      ack_nx    = ack;
      stb_nx    = stb;
      z_nx      = z;
      case (state)
         GET_A: begin
            ack_nx = 1'b1;
            if (ack && io.input_a_stb) begin
               a_nx     = io.input_a;
               rnd_nx   = io.input_rnd;
               ack_nx   = 1'b0;
               state_nx = CONVERT;
            end
         end
         CONVERT: begin
            sign_nx  = sign_c;
            mag_nx   = mag_c;
            zero_nx  = (mag_c == '0);
            state_nx = NORMALISE;
         end
         NORMALISE: begin
            expo_nx   = 8'(lead) + 8'd127;
            mant_nx   = norm[62:40];
            guard_nx  = norm[39];
            sticky_nx = |norm[38:0];
            state_nx  = ROUND;
         end
         ROUND: begin
            if (!rnd && guard && (mant[0] || sticky)) begin
               mant_nx = inc[22:0];
               if (inc[23]) expo_nx = expo + 8'd1;
            end
            state_nx = PACK;
         end
         PACK: begin
            z_nx     = zero ? 32'h0000_0000 : {sign, expo, mant};
            stb_nx   = 1'b1;
            state_nx = PUT_Z;
         end
         PUT_Z: begin
            if (stb && io.output_z_ack) begin
               stb_nx   = 1'b0;
               ack_nx   = 1'b1;
               state_nx = GET_A;
            end
         end
         default: state_nx = GET_A;
      endcase
   end
endmodule

// File: tb/tb_int_to_float_n.sv
// Directed scoreboard bench for int_to_float_n over four width/signedness configurations.
module tb_int_to_float_n;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] a_drv = '0;
   logic        rnd_drv = 1'b0;
   logic [3:0]  stb_drv = '0;
   logic [3:0]  zack_drv = 4'hF;
   logic [3:0]  ack_o, zs_o;
   logic [31:0] z_o [4];

   int total = 0;
   int bad   = 0;

   typedef struct { int k; logic [31:0] z; } exp_t;
   exp_t sb [$];

   always #5 clk = ~clk;

   int_to_float_n_if #(.INT_WIDTH(32)) if0 ();
   int_to_float_n_if #(.INT_WIDTH(32)) if1 ();
   int_to_float_n_if #(.INT_WIDTH(64)) if2 ();
   int_to_float_n_if #(.INT_WIDTH(8))  if3 ();

   int_to_float_n #(.INT_WIDTH(32), .SIGNED(1'b1)) dut0 (.clk(clk), .rst(rst), .io(if0.slave));
   int_to_float_n #(.INT_WIDTH(32), .SIGNED(1'b0)) dut1 (.clk(clk), .rst(rst), .io(if1.slave));
   int_to_float_n #(.INT_WIDTH(64), .SIGNED(1'b0)) dut2 (.clk(clk), .rst(rst), .io(if2.slave));
   int_to_float_n #(.INT_WIDTH(8),  .SIGNED(1'b1)) dut3 (.clk(clk), .rst(rst), .io(if3.slave));

   assign if0.input_a = a_drv[31:0]; assign if0.input_rnd = rnd_drv;
   assign if0.input_a_stb = stb_drv[0]; assign if0.output_z_ack = zack_drv[0];
   assign ack_o[0] = if0.input_a_ack; assign zs_o[0] = if0.output_z_stb; assign z_o[0] = if0.output_z;

   assign if1.input_a = a_drv[31:0]; assign if1.input_rnd = rnd_drv;
   assign if1.input_a_stb = stb_drv[1]; assign if1.output_z_ack = zack_drv[1];
   assign ack_o[1] = if1.input_a_ack; assign zs_o[1] = if1.output_z_stb; assign z_o[1] = if1.output_z;

   assign if2.input_a = a_drv; assign if2.input_rnd = rnd_drv;
   assign if2.input_a_stb = stb_drv[2]; assign if2.output_z_ack = zack_drv[2];
   assign ack_o[2] = if2.input_a_ack; assign zs_o[2] = if2.output_z_stb; assign z_o[2] = if2.output_z;

   assign if3.input_a = a_drv[7:0]; assign if3.input_rnd = rnd_drv;
   assign if3.input_a_stb = stb_drv[3]; assign if3.output_z_ack = zack_drv[3];
   assign ack_o[3] = if3.input_a_ack; assign zs_o[3] = if3.output_z_stb; assign z_o[3] = if3.output_z;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Waits (bounded) for ack, drives one operand for one edge, and queues the expected float.
   task automatic send(input int k, input logic [63:0] a, input logic r, input logic [31:0] ez);
      int n = 0;
      @(negedge clk);
      while (!ack_o[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ack_wait", 64'(n < 20), 64'd1);
      a_drv = a;
      rnd_drv = r;
      stb_drv[k] = 1'b1;
      sb.push_back('{k, ez});
      @(posedge clk);
      #1 stb_drv[k] = 1'b0;
      chk("ack_drop", 64'(ack_o[k]), 64'd0);
   endtask

   // Counts edges to output strobe, compares against the scoreboard head, and
   // checks the handshake after the transfer when downstream is accepting.
   task automatic recv(input int k, input string tag);
      int n = 0;
      exp_t e;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!zs_o[k] && n < 10);
      chk({tag, "_lat"}, 64'(n), 64'd4);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_dut"}, 64'(k), 64'(e.k));
         chk(tag, 64'(z_o[k]), 64'(e.z));
      end
      if (zack_drv[k]) begin
         @(posedge clk);
         #1;
         chk({tag, "_stb_fall"}, 64'(zs_o[k]), 64'd0);
         chk({tag, "_ack_rise"}, 64'(ack_o[k]), 64'd1);
      end
   endtask

   task automatic conv(input int k, input logic [63:0] a, input logic r,
                       input logic [31:0] ez, input string tag);
      send(k, a, r, ez);
      recv(k, tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with upstream strobe asserted.
      stb_drv = 4'b0001;
      a_drv = 64'd1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_ack", 64'(ack_o[0]), 64'd0);
         chk("rst_stb", 64'(zs_o[0]), 64'd0);
         chk("rst_z", 64'(z_o[0]), 64'd0);
      end
      stb_drv = '0;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rel_ack_pre", 64'(ack_o[0]), 64'd0);
      @(posedge clk);
      #1 chk("rel_ack_post", 64'(ack_o[0]), 64'd1);
      conv(0, 64'd1, 1'b0, 32'h3F80_0000, "one");

      // Signed 32-bit, round-to-nearest-even.
      conv(0, 64'hFFFF_FFFF, 1'b0, 32'hBF80_0000, "neg_one");
      conv(0, 64'h8000_0000, 1'b0, 32'hCF00_0000, "most_neg");
      conv(0, 64'd0,         1'b0, 32'h0000_0000, "zero");
      conv(0, 64'd16777217,  1'b0, 32'h4B80_0000, "tie_down");
      conv(0, 64'd16777219,  1'b0, 32'h4B80_0002, "tie_up");

      // Unsigned 32-bit, both rounding modes.
      conv(1, 64'hFFFF_FFFF, 1'b0, 32'h4F80_0000, "u_max_rne");
      conv(1, 64'hFFFF_FFFF, 1'b1, 32'h4F7F_FFFF, "u_max_rtz");
      conv(1, 64'd16777219,  1'b1, 32'h4B80_0001, "u_rtz");

      // Width sweep.
      conv(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h5F80_0000, "w64_max");
      conv(3, 64'h80, 1'b0, 32'hC300_0000, "w8_min");
      conv(3, 64'h7F, 1'b0, 32'h42FE_0000, "w8_max");

      // Back-pressure: stall 20 cycles with stray upstream pulses.
      zack_drv[0] = 1'b0;
      conv(0, 64'd7, 1'b0, 32'h40E0_0000, "bp");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         stb_drv[0] = i[0];
         a_drv = 64'($urandom);
         @(posedge clk);
         #1;
         chk("bp_z", 64'(z_o[0]), 64'h40E0_0000);
         chk("bp_stb", 64'(zs_o[0]), 64'd1);
         chk("bp_ack", 64'(ack_o[0]), 64'd0);
      end
      @(negedge clk);
      stb_drv[0] = 1'b0;
      zack_drv[0] = 1'b1;
      @(posedge clk);
      #1 zack_drv[0] = 1'b0;
      chk("bp_release_stb", 64'(zs_o[0]), 64'd0);
      chk("bp_release_ack", 64'(ack_o[0]), 64'd1);
      repeat (6) begin
         @(posedge clk);
         #1 chk("bp_single", 64'(zs_o[0]), 64'd0);
      end
      chk("bp_sb", 64'(sb.size()), 64'd0);
      zack_drv[0] = 1'b1;

      // Reset while the operand sits in ROUND.
      send(0, 64'd9, 1'b0, 32'h4110_0000);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_ack", 64'(ack_o[0]), 64'd0);
      chk("mid_rst_stb", 64'(zs_o[0]), 64'd0);
      chk("mid_rst_z", 64'(z_o[0]), 64'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1 chk("no_stale", 64'(zs_o[0]), 64'd0);
      end
      conv(0, 64'd5, 1'b0, 32'h40A0_0000, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
